// File: rtl/cswap_chk_pkg.sv
// cswap_chk_pkg
//   Shared definitions for the controlled-swap (Fredkin) stage checker:
//   run-control FSM state encoding and the "every input combination seen"
//   coverage constant.
package cswap_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // All eight {a,b,c} combinations have been accepted.
    localparam logic [7:0] COV_ALL = 8'hFF;

endpackage

// File: rtl/cswap_ref_model.sv
// cswap_ref_model
//   Golden combinational controlled-swap: a is the control and passes
//   straight through; when a=1, b and c are exchanged.
// Ports:
//   a, b, c       : stage inputs (a = control)
//   e_a, e_b, e_c : expected stage outputs
module cswap_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic e_a,
    output logic e_b,
    output logic e_c
);

    assign e_a = a;
    assign e_b = a ? c : b;
    assign e_c = a ? b : c;

endmodule

// File: rtl/cswap_checker.sv
// cswap_checker
//   Run-based checker for a controlled-swap stage. A run is started with
//   start, accepts vectors through a valid/ready handshake, compares the
//   stage outputs against cswap_ref_model and records vector count, error
//   count and input-combination coverage. A run ends after NUM_VEC vectors
//   (NUM_VEC=0: only on stop) or on stop.
// Parameters:
//   CNT_W   : width of vec_cnt / err_cnt (both saturate at all-ones)
//   NUM_VEC : vectors per run, 0 = unlimited
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, stop          : begin/restart a run, end the current run early
//   in_valid / in_ready  : vector handshake (ready only while running)
//   a, b, c              : stage inputs;  a1, b1, c1 : stage outputs
//   busy, done, pass     : run in progress, run finished, clean+covered
//   vec_cnt, err_cnt     : accepted / mismatching vectors this run
//   cov_map              : bit {a,b,c} set once that combination is accepted
// Optional feature (macro CSWAP_CHK_FIRST_ERR_EN):
//   first_err_vld, first_err_vec : first mismatch of the run, {a,b,c,a1,b1,c1}
module cswap_checker
    import cswap_chk_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int NUM_VEC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             a1,
    input  logic             b1,
    input  logic             c1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov_map
`ifdef CSWAP_CHK_FIRST_ERR_EN
    ,
    output logic             first_err_vld,
    output logic [5:0]       first_err_vec
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [7:0]       r_cov_map;

    logic             w_e_a, w_e_b, w_e_c;
    logic             w_accept;
    logic             w_start_run;
    logic             w_mismatch;
    logic             w_last;
    logic [CNT_W-1:0] w_vec_inc;
    logic [CNT_W-1:0] w_err_inc;
    logic [7:0]       w_cov_bit;

    cswap_ref_model u_ref (
        .a   (a),
        .b   (b),
        .c   (c),
        .e_a (w_e_a),
        .e_b (w_e_b),
        .e_c (w_e_c)
    );

    assign w_accept    = in_valid && (r_state == ST_RUN);
    // start is only honoured outside RUN; a restart from DONE clears on the same edge.
    assign w_start_run = start && (r_state != ST_RUN);
    assign w_mismatch  = {a1, b1, c1} != {w_e_a, w_e_b, w_e_c};
    assign w_vec_inc   = (r_vec_cnt == '1) ? r_vec_cnt : r_vec_cnt + 1'b1;
    assign w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
    assign w_cov_bit   = 8'd1 << {a, b, c};
    // Run ends on the edge where the count reaches NUM_VEC.
    assign w_last      = (NUM_VEC != 0) && (w_vec_inc == CNT_W'(NUM_VEC));

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (stop || (w_accept && w_last)) w_state_nxt = ST_DONE;
            ST_DONE: if (start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A vector coinciding with stop is still counted before entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_cov_map <= '0;
        end else if (w_start_run) begin
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_cov_map <= '0;
        end else if (w_accept) begin
            r_vec_cnt <= w_vec_inc;
            if (w_mismatch) r_err_cnt <= w_err_inc;
            r_cov_map <= r_cov_map | w_cov_bit;
        end
    end

`ifdef CSWAP_CHK_FIRST_ERR_EN
    logic       r_first_err_vld;
    logic [5:0] r_first_err_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_err_vld <= 1'b0;
            r_first_err_vec <= '0;
        end else if (w_start_run) begin
            r_first_err_vld <= 1'b0;
            r_first_err_vec <= '0;
        end else if (w_accept && w_mismatch && !r_first_err_vld) begin
            r_first_err_vld <= 1'b1;
            r_first_err_vec <= {a, b, c, a1, b1, c1};
        end
    end

    assign first_err_vld = r_first_err_vld;
    assign first_err_vec = r_first_err_vec;
`endif

    assign in_ready = (r_state == ST_RUN);
    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign pass     = done && (r_err_cnt == '0) && (r_cov_map == COV_ALL);
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign cov_map  = r_cov_map;

endmodule
